// File: rtl/req_ack_mon_pkg.sv
// Shared types and helpers for the req/ack protocol monitor.
// Holds the per-channel state encoding and a width-generic saturating adder.
package req_ack_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_e;

    // Adds two values and clamps the result to the largest value that fits in 'width' bits.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned width
    );
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/req_ack_chan.sv
// One req/ack channel: edge detection, IDLE/WAIT tracking, latency counter
// and the channel's own registered result and error pulses.
module req_ack_chan
    import req_ack_mon_pkg::*;
#(
    parameter int unsigned MAX_LAT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             ack_i,
    output logic             pending_o,
    output logic             lat_valid_o,
    output logic [CNT_W-1:0] lat_value_o,
    output logic             timeout_o,
    output logic             orphan_o,
    output logic             overlap_o
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             req_q, ack_q;
    logic             req_rise, ack_rise;
    logic             timeout_hit;

    logic             lat_valid_q, lat_valid_d;
    logic [CNT_W-1:0] lat_value_q, lat_value_d;
    logic             timeout_q, timeout_d;
    logic             orphan_q, orphan_d;
    logic             overlap_q, overlap_d;

    assign req_rise = req_i & ~req_q;
    assign ack_rise = ack_i & ~ack_q;
    assign cnt_inc  = CNT_W'(sat_add(32'(cnt_q), 32'd1, CNT_W));

    // The unsaturated cnt+1 is compared so a limit equal to 2^CNT_W can still fire.
    generate
        if (MAX_LAT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = ((33'(cnt_q) + 33'd1) == 33'(MAX_LAT));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            lat_valid_q <= 1'b0;
            lat_value_q <= '0;
            timeout_q   <= 1'b0;
            orphan_q    <= 1'b0;
            overlap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_i;
            ack_q       <= ack_i;
            lat_valid_q <= lat_valid_d;
            lat_value_q <= lat_value_d;
            timeout_q   <= timeout_d;
            orphan_q    <= orphan_d;
            overlap_q   <= overlap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // A second req rise does not restart the measurement.
                if (ack_rise || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        lat_valid_d = 1'b0;
        lat_value_d = '0;
        timeout_d   = 1'b0;
        orphan_d    = 1'b0;
        overlap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                orphan_d = ack_rise;
            end
            WAIT: begin
                lat_valid_d = ack_rise;
                lat_value_d = ack_rise ? cnt_inc : '0;
                timeout_d   = timeout_hit & ~ack_rise;
                overlap_d   = req_rise;
            end
            default: begin
                orphan_d = 1'b0;
            end
        endcase
    end

    assign pending_o   = (state_q == WAIT);
    assign lat_valid_o = lat_valid_q;
    assign lat_value_o = lat_value_q;
    assign timeout_o   = timeout_q;
    assign orphan_o    = orphan_q;
    assign overlap_o   = overlap_q;

endmodule

// File: rtl/req_ack_monitor.sv
// Multi-channel req/ack protocol monitor: per-channel latency and error pulses plus
// a saturating error total. Define REQ_ACK_MON_STRONG_EN to flag eot while requests are open.
module req_ack_monitor
    import req_ack_mon_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MAX_LAT = 0,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ERRC_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       ack,
    input  logic                    eot,
    output logic [NUM_CH-1:0]       pending,
    output logic [NUM_CH-1:0]       lat_valid,
    output logic [NUM_CH*CNT_W-1:0] lat_value,
    output logic [NUM_CH-1:0]       timeout_err,
    output logic [NUM_CH-1:0]       orphan_err,
    output logic [NUM_CH-1:0]       overlap_err,
    output logic                    unfinished_err,
    output logic [ERRC_W-1:0]       err_count
);

    localparam int unsigned ERR_BITS = 3 * NUM_CH + 1;

    logic                unfinished_q, unfinished_d;
    logic [ERRC_W-1:0]   err_count_q, err_count_d;
    logic [ERR_BITS-1:0] err_vec;
    logic [31:0]         err_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            req_ack_chan #(
                .MAX_LAT (MAX_LAT),
                .CNT_W   (CNT_W)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .req_i       (req[gi]),
                .ack_i       (ack[gi]),
                .pending_o   (pending[gi]),
                .lat_valid_o (lat_valid[gi]),
                .lat_value_o (lat_value[gi*CNT_W +: CNT_W]),
                .timeout_o   (timeout_err[gi]),
                .orphan_o    (orphan_err[gi]),
                .overlap_o   (overlap_err[gi])
            );
        end
    endgenerate

`ifdef REQ_ACK_MON_STRONG_EN
    assign unfinished_d = eot & (|pending);
`else
    logic unused_eot;
    assign unused_eot   = eot;
    assign unfinished_d = 1'b0;
`endif

    // The total follows the registered pulses, so it settles one cycle after them.
    assign err_vec = {unfinished_q, overlap_err, orphan_err, timeout_err};

    always_comb begin
        err_inc = '0;
        for (int i = 0; i < int'(ERR_BITS); i++) begin
            err_inc = err_inc + 32'(err_vec[i]);
        end
        err_count_d = ERRC_W'(sat_add(32'(err_count_q), err_inc, ERRC_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unfinished_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            unfinished_q <= unfinished_d;
            err_count_q  <= err_count_d;
        end
    end

    assign unfinished_err = unfinished_q;
    assign err_count      = err_count_q;

endmodule
